// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, requester indices and helpers for the write-back arbiter.
package regfile_wb_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_WB_REQ = 3;
    localparam int WB_ALU = 0;
    localparam int WB_MUL = 1;
    localparam int WB_LSU = 2;
    function automatic int ptr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant over a request vector, pointer advances past each accepted winner.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ,
    localparam int IW = ptr_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);
    logic [IW-1:0] ptr;
    int sel;
    always_comb begin
        sel = 0;
        // descending scan so the requester closest to ptr is the last to overwrite sel
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) sel = (int'(ptr) + k) % NUM_REQ;
        end
        idx = IW'(sel);
        grant = (|req && !reset) ? NUM_REQ'(1) << sel : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (accept) ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among execute units and tracks pending writes.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_addr,
    output logic [(1<<ADDR_W)-1:0]    busy
);
    localparam int NR = 1 << ADDR_W;
    localparam int IW = ptr_w(NUM_REQ);
    logic [IW-1:0] idx;
    logic hs;
    logic [ADDR_W-1:0] ga;
    logic [DATA_W-1:0] gd;
    logic [NR-1:0] set, clr;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk(clk),
        .reset(reset),
        .req(req_valid),
        .accept(hs),
        .grant(req_ready),
        .idx(idx)
    );
    assign hs = |req_ready;
    always_comb begin
        ga = req_addr[int'(idx)*ADDR_W +: ADDR_W];
        gd = req_data[int'(idx)*DATA_W +: DATA_W];
        set = issue_valid ? NR'(1) << issue_addr : '0;
        clr = hs ? NR'(1) << ga : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy <= '0;
        end else begin
            wr_en <= hs;
            if (hs) begin
                wr_addr <= ga;
                wr_data <= gd;
            end
            // a new issue outranks a completing write to the same register
            busy <= (busy & ~clr) | set;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration order, write staging, scoreboard and reset.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [31:0] busy;
    int vectors = 0;
    int miscompares = 0;

    regfile_wb_arbiter dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_data(req_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .issue_valid(issue_valid),
        .issue_addr(issue_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5] = a;
        req_data[i*32 +: 32] = d;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 3'b111;
        req_addr = '0;
        req_data = '0;
        issue_valid = 1'b0;
        issue_addr = '0;
        tick();
        tick();
        chk("ready_in_reset", req_ready, 3'b000);
        req_valid = 3'b000;
        reset = 1'b0;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_wr_en", wr_en, 0);
            chk("idle_busy", busy, 0);
            chk("idle_ready", req_ready, 0);
        end

        set_req(0, 5'd3, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1 chk("single_ready", req_ready, 3'b001);
        tick();
        req_valid = 3'b000;
        chk("single_wr_en", wr_en, 1);
        chk("single_wr_addr", wr_addr, 3);
        chk("single_wr_data", wr_data, 32'hDEADBEEF);
        tick();
        chk("single_wr_en_drop", wr_en, 0);
        chk("single_addr_hold", wr_addr, 3);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 5'd1, 32'hA0A0A0A0);
        set_req(1, 5'd2, 32'hB1B1B1B1);
        set_req(2, 5'd3, 32'hC2C2C2C2);
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1 chk("rr_ready", req_ready, 3'b001 << (i % 3));
            tick();
            chk("rr_wr_en", wr_en, 1);
            chk("rr_wr_addr", wr_addr, (i % 3) + 1);
            chk("rr_wr_data", wr_data, (i % 3) == 0 ? 32'hA0A0A0A0 : (i % 3) == 1 ? 32'hB1B1B1B1 : 32'hC2C2C2C2);
        end
        req_valid = 3'b000;
        tick();
        chk("rr_wr_en_drop", wr_en, 0);

        issue_valid = 1'b1;
        issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("sb_set7", busy, 32'h0000_0080);
        tick();
        tick();
        chk("sb_hold7", busy, 32'h0000_0080);
        set_req(1, 5'd7, 32'h7777_0001);
        req_valid = 3'b010;
        #1 chk("sb_mul_ready", req_ready, 3'b010);
        tick();
        req_valid = 3'b000;
        chk("sb_mul_wr_en", wr_en, 1);
        chk("sb_mul_wr_addr", wr_addr, 7);
        chk("sb_clr7", busy, 0);

        issue_valid = 1'b1;
        issue_addr = 5'd9;
        tick();
        chk("sb_set9", busy, 32'h0000_0200);
        set_req(1, 5'd9, 32'h9999_0009);
        req_valid = 3'b010;
        tick();
        issue_valid = 1'b0;
        req_valid = 3'b000;
        chk("sb_same_wr_addr", wr_addr, 9);
        chk("sb_set_wins", busy, 32'h0000_0200);
        set_req(0, 5'd12, 32'h1212_1212);
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        chk("sb_noop_wr_addr", wr_addr, 12);
        chk("sb_noop_clear", busy, 32'h0000_0200);

        set_req(2, 5'd5, 32'h5555_5555);
        req_valid = 3'b100;
        issue_valid = 1'b1;
        issue_addr = 5'd4;
        #1 chk("lsu_ready", req_ready, 3'b100);
        tick();
        req_valid = 3'b111;
        issue_valid = 1'b0;
        reset = 1'b1;
        chk("lsu_wr_data", wr_data, 32'h5555_5555);
        chk("lsu_busy", busy, 32'h0000_0210);
        #1 chk("lsu_ready_reset", req_ready, 0);
        tick();
        reset = 1'b0;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_busy", busy, 0);
        #1 chk("mid_rst_ready", req_ready, 3'b001);

        req_valid = 3'b001;
        tick();
        req_valid = 3'b111;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 chk("ptr_rst_ready", req_ready, 3'b001);
        tick();
        req_valid = 3'b000;
        chk("ptr_rst_wr_data", wr_data, 32'h1212_1212);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
